// File: rtl/ip_tx_assembler_pkg.sv
// Shared constants, state encoding and address/length types for the IPv4 transmit path.
package ip_pkg;

    localparam int unsigned IP_HDR_BYTES   = 20;
    localparam int unsigned IP_MAX_PAYLOAD = 1480;

    typedef logic [31:0] ipv4_addr_t;
    typedef logic [15:0] ip_len_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HDR,
        PAY
    } tx_state_e;

    function automatic logic len_in_range(input ip_len_t len, input ip_len_t max_len);
        return (len != '0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/ip_tx_assembler_hdr_buffer.sv
// Small register file holding one encoded IPv4 header; written and read by byte index.
module hdr_buffer
    import ip_pkg::*;
#(
    parameter int unsigned DEPTH = IP_HDR_BYTES,
    parameter int unsigned IDX_W = $clog2(IP_HDR_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (wr_idx < IDX_W'(DEPTH))) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = (rd_idx < IDX_W'(DEPTH)) ? mem_q[rd_idx] : '0;

endmodule

// File: rtl/ip_tx_assembler.sv
// Captures the encoder's header bytes for one send request, then streams header
// followed by the pass-through payload as a single valid/ready datagram.
module ip_tx_assembler
    import ip_pkg::*;
#(
    parameter int unsigned HDR_BYTES   = IP_HDR_BYTES,
    parameter int unsigned MAX_PAYLOAD = IP_MAX_PAYLOAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_sa,
    input  logic [31:0] req_da,
    input  logic [15:0] req_len,
    output logic        req_err,
    output logic        enc_en,
    output logic [31:0] enc_sa,
    output logic [31:0] enc_da,
    output logic [15:0] enc_len,
    input  logic [7:0]  enc_byte,
    input  logic        enc_ovalid,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready
);

    localparam int unsigned      CNT_W     = $clog2(HDR_BYTES + 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(HDR_BYTES);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BYTES - 1);
    localparam ip_len_t          MAX_LEN   = ip_len_t'(MAX_PAYLOAD);
    localparam ip_len_t          HDR_LEN   = ip_len_t'(HDR_BYTES);

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    ip_len_t          len_q;
    ip_len_t          rem_q;
    logic             req_ready_q;
    logic             req_err_q;
    logic             enc_en_q;
    ipv4_addr_t       enc_sa_q;
    ipv4_addr_t       enc_da_q;
    ip_len_t          enc_len_q;

    logic             buf_wr_en;
    logic [7:0]       buf_rd_data;

    // Fill cycle 0 carries no header byte; cycles 1..N store byte (cnt-1).
    assign buf_wr_en = (state_q == FILL) && (cnt_q != '0);

    hdr_buffer #(
        .DEPTH(HDR_BYTES),
        .IDX_W(CNT_W)
    ) u_hdr_buffer (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (buf_wr_en),
        .wr_idx (cnt_q - CNT_W'(1)),
        .wr_data(enc_byte),
        .rd_idx (cnt_q),
        .rd_data(buf_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            req_ready_q <= 1'b0;
            req_err_q   <= 1'b0;
            enc_en_q    <= 1'b0;
            enc_sa_q    <= '0;
            enc_da_q    <= '0;
            enc_len_q   <= '0;
        end else begin
            req_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        if (len_in_range(req_len, MAX_LEN)) begin
                            enc_sa_q    <= req_sa;
                            enc_da_q    <= req_da;
                            enc_len_q   <= req_len + HDR_LEN;
                            len_q       <= req_len;
                            enc_en_q    <= 1'b1;
                            cnt_q       <= '0;
                            req_ready_q <= 1'b0;
                            state_q     <= FILL;
                        end else begin
                            req_err_q <= 1'b1;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (cnt_q == FILL_LAST) begin
                        enc_en_q <= 1'b0;
                        cnt_q    <= '0;
                        if (enc_ovalid) begin
                            state_q <= HDR;
                        end else begin
                            req_err_q   <= 1'b1;
                            req_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HDR: begin
                    if (m_ready) begin
                        if (cnt_q == HDR_LAST) begin
                            cnt_q   <= '0;
                            rem_q   <= len_q;
                            state_q <= PAY;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                PAY: begin
                    if (s_valid && m_ready) begin
                        rem_q <= rem_q - ip_len_t'(1);
                        if (rem_q == ip_len_t'(1)) begin
                            req_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Payload is a zero-latency pass-through; only the header comes from the buffer.
    always_comb begin
        m_data  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        s_ready = 1'b0;
        unique case (state_q)
            HDR: begin
                m_valid = 1'b1;
                m_data  = buf_rd_data;
            end
            PAY: begin
                m_valid = s_valid;
                m_data  = s_data;
                s_ready = m_ready;
                m_last  = (rem_q == ip_len_t'(1));
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_q;
    assign req_err   = req_err_q;
    assign enc_en    = enc_en_q;
    assign enc_sa    = enc_sa_q;
    assign enc_da    = enc_da_q;
    assign enc_len   = enc_len_q;

endmodule

// File: tb/tb_ip_tx_assembler.sv
// Bench for ip_tx_assembler: behavioural encoder, datagram scoreboard, directed and random traffic.
module tb_ip_tx_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_sa = '0;
    logic [31:0] req_da = '0;
    logic [15:0] req_len = '0;
    logic        req_err;
    logic        enc_en;
    logic [31:0] enc_sa;
    logic [31:0] enc_da;
    logic [15:0] enc_len;
    logic [7:0]  enc_byte;
    logic        enc_ovalid;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ip_tx_assembler #(
        .HDR_BYTES  (20),
        .MAX_PAYLOAD(1480)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sa    (req_sa),
        .req_da    (req_da),
        .req_len   (req_len),
        .req_err   (req_err),
        .enc_en    (enc_en),
        .enc_sa    (enc_sa),
        .enc_da    (enc_da),
        .enc_len   (enc_len),
        .enc_byte  (enc_byte),
        .enc_ovalid(enc_ovalid),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    // Encoder model: header byte k is presented on the (k+1)th cycle after enc_en is seen.
    logic [7:0] hdr [20];
    int         ecnt = 0;
    bit         enc_fault = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= enc_en ? ecnt + 1 : 0;
    end

    always_comb begin
        enc_byte   = (ecnt >= 1 && ecnt <= 20) ? hdr[ecnt-1] : 8'h00;
        enc_ovalid = (ecnt == 20) && !enc_fault;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue_request(input logic [31:0] sa, input logic [31:0] da, input int len);
        int w;
        @(negedge clk);
        req_valid = 1'b1;
        req_sa    = sa;
        req_da    = da;
        req_len   = 16'(len);
        #1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("req_ready_in_idle", req_ready, 1);
    endtask

    task automatic run_dgram(input logic [31:0] sa, input logic [31:0] da, input int len,
                             input int rmode, input int stall_at, input int abort_at,
                             input int exp_enc_len);
        logic [7:0] exp_q[$];
        logic [7:0] pay[$];
        logic [7:0] held_data;
        bit         held;
        bit         stalling;
        int         pidx, n, cyc, first_v, total, limit, stall_left;
        pidx = 0; n = 0; cyc = 0; first_v = -1; held = 0; held_data = '0; stall_left = 5;
        total = 20 + len;
        limit = 4 * total + 80;
        foreach (hdr[i]) begin
            hdr[i] = 8'($urandom);
            exp_q.push_back(hdr[i]);
        end
        if (len == 4) pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        else for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
        foreach (pay[i]) exp_q.push_back(pay[i]);

        issue_request(sa, da, len);
        while (n < total) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) req_valid = 1'b0;
            if (cyc > limit) begin
                check("dgram_timeout", n, total);
                break;
            end
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = cyc[0];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            stalling = (stall_at >= 0) && (n >= 20) && (pidx == stall_at) && (stall_left > 0);
            s_valid  = !stalling && (pidx < len) && (rmode < 2 || $urandom_range(0, 3) != 0);
            s_data   = s_valid ? pay[pidx] : 8'($urandom);
            #1;
            if (cyc == 1) begin
                check("enc_en_start", enc_en, 1);
                check("enc_len", enc_len, 32'(exp_enc_len));
                check("enc_sa", enc_sa, sa);
                check("enc_da", enc_da, da);
                check("req_ready_busy", req_ready, 0);
            end
            if (held) begin
                check("hdr_hold_valid", m_valid, 1);
                check("hdr_hold_data", m_data, held_data);
            end
            if (n < 20) begin
                check("s_ready_outside_pay", s_ready, 0);
            end else begin
                check("s_ready_tracks_m_ready", s_ready, m_ready);
                check("m_valid_tracks_s_valid", m_valid, s_valid);
            end
            if (m_valid && first_v < 0) begin
                first_v = cyc;
                check("first_valid_latency", cyc, 22);
            end
            held = (n < 20) && m_valid && !m_ready;
            held_data = m_data;
            if (stalling) stall_left--;
            if (m_valid && m_ready) begin
                check("m_data", m_data, exp_q[n]);
                check("m_last", m_last, 32'(n == total - 1));
                if (n >= 20) pidx++;
                n++;
                if (n == abort_at) begin
                    @(posedge clk);
                    #2;
                    check("pre_reset_valid", m_valid, 1);
                    check("pre_reset_data", m_data, exp_q[n]);
                    rst_n = 1'b0;
                    #1;
                    check("rst_m_valid", m_valid, 0);
                    check("rst_m_data", m_data, 0);
                    check("rst_m_last", m_last, 0);
                    check("rst_s_ready", s_ready, 0);
                    check("rst_req_ready", req_ready, 0);
                    check("rst_enc_en", enc_en, 0);
                    check("rst_enc_len", enc_len, 0);
                    @(negedge clk);
                    rst_n   = 1'b1;
                    m_ready = 1'b0;
                    s_valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        m_ready = 1'b0;
        s_valid = 1'b0;
        #1;
        check("req_ready_after_dgram", req_ready, 1);
        check("m_valid_after_dgram", m_valid, 0);
    endtask

    task automatic run_reject(input int len);
        int pulses, en_seen, v_seen;
        pulses = 0; en_seen = 0; v_seen = 0;
        m_ready = 1'b1;
        issue_request(32'h0A000001, 32'h0A000002, len);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            #1;
            if (i == 0) check("reject_err_pulse", req_err, 1);
            pulses  += int'(req_err);
            en_seen += int'(enc_en);
            v_seen  += int'(m_valid);
            @(negedge clk);
        end
        #1;
        check("reject_pulse_count", pulses, 1);
        check("reject_enc_en_never", en_seen, 0);
        check("reject_m_valid_never", v_seen, 0);
        check("reject_req_ready", req_ready, 1);
        m_ready = 1'b0;
    endtask

    task automatic run_enc_fault();
        int pulses, first_err, v_seen, sr_seen;
        pulses = 0; first_err = -1; v_seen = 0; sr_seen = 0;
        foreach (hdr[i]) hdr[i] = 8'($urandom);
        enc_fault = 1'b1;
        m_ready   = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'h55;
        issue_request(32'hC0A80001, 32'hC0A80002, 4);
        for (int cyc = 1; cyc <= 35; cyc++) begin
            @(negedge clk);
            if (cyc == 1) req_valid = 1'b0;
            #1;
            if (req_err && first_err < 0) first_err = cyc;
            pulses  += int'(req_err);
            v_seen  += int'(m_valid);
            sr_seen += int'(s_ready);
        end
        check("fault_err_cycle", first_err, 22);
        check("fault_pulse_count", pulses, 1);
        check("fault_no_output", v_seen, 0);
        check("fault_no_drain", sr_seen, 0);
        check("fault_back_idle", req_ready, 1);
        enc_fault = 1'b0;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
    endtask

    typedef struct {
        int len;
        bit rej;
        int rmode;
        int stall;
        int exp_enc_len;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{len: 4,     rej: 0, rmode: 0, stall: -1, exp_enc_len: 24};
        tbl[1] = '{len: 4,     rej: 0, rmode: 1, stall: -1, exp_enc_len: 24};
        tbl[2] = '{len: 4,     rej: 0, rmode: 0, stall: 2,  exp_enc_len: 24};
        tbl[3] = '{len: 0,     rej: 1, rmode: 0, stall: -1, exp_enc_len: 0};
        tbl[4] = '{len: 1481,  rej: 1, rmode: 0, stall: -1, exp_enc_len: 0};
        tbl[5] = '{len: 65535, rej: 1, rmode: 0, stall: -1, exp_enc_len: 0};
        tbl[6] = '{len: 1,     rej: 0, rmode: 0, stall: -1, exp_enc_len: 21};
        tbl[7] = '{len: 1480,  rej: 0, rmode: 2, stall: -1, exp_enc_len: 1500};

        m_ready = 1'b1;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_s_ready", s_ready, 0);
        check("reset_enc_en", enc_en, 0);
        check("reset_req_err", req_err, 0);
        check("reset_enc_len", enc_len, 0);
        m_ready = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].rej) run_reject(tbl[i].len);
            else run_dgram(32'hC0A80001, 32'hC0A80002, tbl[i].len, tbl[i].rmode,
                           tbl[i].stall, -1, tbl[i].exp_enc_len);
        end

        run_enc_fault();

        run_dgram(32'hC0A80001, 32'hC0A80002, 4, 0, -1, 7, 24);
        run_dgram(32'hC0A80003, 32'hC0A80004, 4, 0, -1, -1, 24);

        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 48);
            run_dgram($urandom, $urandom, len, 2, (r % 2 == 0) ? int'($urandom_range(0, len - 1)) : -1,
                      -1, len + 20);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
